// File: rtl/hack_ram4_if.sv
// Bus bundle for hack_ram4: write data, load strobe, word address and the read result.
// Master is the datapath side; slave is the register file.
interface hack_ram4_if #(parameter int WIDTH = 16);
  logic [WIDTH-1:0] in;
  logic             load;
  logic [1:0]       address;
  logic [WIDTH-1:0] out;
  logic             out_valid;

  modport master (output in, output load, output address, input out, input out_valid);
  modport slave  (input in, input load, input address, output out, output out_valid);
endinterface

// File: rtl/hack_ram4.sv
// 4 x WIDTH register file with per-word written-since-reset flags; HACK_RAM4_BYPASS_EN adds write-through.
// Latency: writes land on the rising edge, reads are combinational from state and address.
// Backpressure: none; a write is accepted on every edge that load is high.
module hack_ram4 #(
  parameter int WIDTH = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  hack_ram4_if.slave   bus
);

  logic [WIDTH-1:0] word [4];
  logic [3:0]       valid;
  logic             a, b, c, d;

  // dmux4_way fan-out of load into the four word enables
  always_comb begin
    a = bus.load & (bus.address == 2'd0);
    b = bus.load & (bus.address == 2'd1);
    c = bus.load & (bus.address == 2'd2);
    d = bus.load & (bus.address == 2'd3);
  end

  logic [3:0] word_load;
  assign word_load = {d, c, b, a};

  for (genvar i = 0; i < 4; i++) begin : g_word
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        word[i]  <= '0;
        valid[i] <= 1'b0;
      end else if (word_load[i]) begin
        word[i]  <= bus.in;
        valid[i] <= 1'b1;
      end
    end
  end

`ifdef HACK_RAM4_BYPASS_EN
  // Forward the write data so the datapath sees it in the same cycle
  always_comb begin
    if (bus.load) begin
      bus.out       = bus.in;
      bus.out_valid = 1'b1;
    end else begin
      bus.out       = word[bus.address];
      bus.out_valid = valid[bus.address];
    end
  end
`else
  always_comb begin
    bus.out       = word[bus.address];
    bus.out_valid = valid[bus.address];
  end
`endif

endmodule

// File: tb/tb_hack_ram4.sv
// Directed and random bench for hack_ram4 against an array-based model of the four words.
module tb_hack_ram4;
  localparam int WIDTH = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;

  logic [WIDTH-1:0] mem [4];
  logic             vld [4];

  hack_ram4_if #(.WIDTH(WIDTH)) bus ();

  hack_ram4 #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [WIDTH:0] model_read();
`ifdef HACK_RAM4_BYPASS_EN
    if (bus.load === 1'b1) return {1'b1, bus.in};
`endif
    return {vld[bus.address], mem[bus.address]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      mem[i] = '0;
      vld[i] = 1'b0;
    end
  endtask

  task automatic check(input string tag, input logic [WIDTH:0] obs, input logic [WIDTH:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed valid/data %h required %h", tag, obs, exp);
  endtask

  task automatic check_read(input string tag, input logic [1:0] addr);
    bus.address = addr;
    #1;
    check(tag, {bus.out_valid, bus.out}, model_read());
  endtask

  task automatic do_write(input logic [1:0] addr, input logic [WIDTH-1:0] data);
    @(negedge clk);
    bus.address = addr;
    bus.in      = data;
    bus.load    = 1'b1;
    @(posedge clk);
    mem[addr] = data;
    vld[addr] = 1'b1;
    #1;
    bus.load = 1'b0;
  endtask

  logic [WIDTH-1:0] wdata [4];

  initial begin
    model_reset();
    wdata[0] = 16'h1111; wdata[1] = 16'h2222; wdata[2] = 16'h3333; wdata[3] = 16'h4444;

    // Reset holds everything at zero even with load asserted
    bus.in = 16'hFFFF;
    bus.load = 1'b1;
    bus.address = 2'd0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.address = 2'(i);
      @(posedge clk);
      #1;
      check("reset_sweep", {bus.out_valid, bus.out}, {1'b0, 16'h0000});
    end
    @(negedge clk);
    bus.load = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) check_read("post_reset", 2'(i));

    // Write then read back each word
    for (int i = 0; i < 4; i++) do_write(2'(i), wdata[i]);
    for (int i = 0; i < 4; i++) begin
      check_read("readback", 2'(i));
      check("readback_const", {bus.out_valid, bus.out}, {1'b1, wdata[i]});
    end

    // Isolation: rewriting one word leaves others alone
    do_write(2'd2, 16'hBEEF);
    for (int i = 0; i < 4; i++) check_read("isolation", 2'(i));
    check_read("isolation_addr2", 2'd2);
    check("isolation_beef", {bus.out_valid, bus.out}, {1'b1, 16'hBEEF});

    // Read during write to the same address
    @(negedge clk);
    bus.address = 2'd1;
    bus.in = 16'hA5A5;
    bus.load = 1'b1;
    #1;
`ifdef HACK_RAM4_BYPASS_EN
    check("rdw_before", {bus.out_valid, bus.out}, {1'b1, 16'hA5A5});
`else
    check("rdw_before", {bus.out_valid, bus.out}, {1'b1, 16'h2222});
`endif
    @(posedge clk);
    mem[1] = 16'hA5A5;
    #1;
    bus.load = 1'b0;
    #1;
    check("rdw_after", {bus.out_valid, bus.out}, {1'b1, 16'hA5A5});

    // Async reset between edges takes effect without a clock
    @(negedge clk);
    bus.address = 2'd3;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", {bus.out_valid, bus.out}, {1'b0, 16'h0000});
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) check_read("after_async", 2'(i));

    // Sticky valid: writing zero still marks the word
    do_write(2'd3, 16'h0000);
    for (int i = 0; i < 4; i++) check_read("sticky", 2'(i));
    check_read("sticky_addr3", 2'd3);
    check("sticky_addr3_const", {bus.out_valid, bus.out}, {1'b1, 16'h0000});

    // Reset arriving in a load cycle blocks the write
    @(negedge clk);
    bus.address = 2'd0;
    bus.in = 16'h1234;
    bus.load = 1'b1;
    #2;
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    bus.load = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_read("reset_mid_write", 2'd0);
    check_read("reset_mid_write_a3", 2'd3);

    // Random traffic against the model
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      bus.address = 2'($urandom_range(0, 3));
      bus.load    = ($urandom_range(0, 2) == 0);
      bus.in      = 16'($urandom);
      #1;
      check("rnd_pre", {bus.out_valid, bus.out}, model_read());
      @(posedge clk);
      if (bus.load) begin
        mem[bus.address] = bus.in;
        vld[bus.address] = 1'b1;
      end
      #1;
      check("rnd_post", {bus.out_valid, bus.out}, model_read());
    end
    bus.load = 1'b0;
    for (int i = 0; i < 4; i++) check_read("rnd_final", 2'(i));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
